mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux (a tree of 2:1 select stages) among four requesters.
- Sequences the mux select lines through a request/grant/done handshake.
- Sits between requesting datapath units and a single shared output bus (e.g. display or register-file write port).
- Guarantees a one-hot grant and a bounded hold time per owner.

Parameters:
- DW, 8, width of each data input and of Dout
- MAX_HOLD, 15, maximum grant length in clock cycles (1..2**HOLD_W-1)
- HOLD_W, 4, width of hold counter

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Req  in  4  request per requester, level, held until granted and done
- Done  in  4  single-cycle release pulse from requester i
- Din0  in  DW  data from requester 0
- Din1  in  DW  data from requester 1
- Din2  in  DW  data from requester 2
- Din3  in  DW  data from requester 3
- Gnt  out  4  one-hot grant, registered
- Sel  out  2  mux select index of current owner, registered
- Dout  out  DW  selected data; Din[Sel] while Busy, else 0 (combinational from Sel)
- Busy  out  1  high in GRANT state

Behaviour:
- Clock and reset: one clock (Clock). Reset is asynchronous, active-high.
- Reset values: Gnt=0000, Sel=00, Busy=0, Dout=0, hold counter=0, Last=3, state=IDLE. The first winner after reset is the lowest requesting index starting at 0.
- States: IDLE, GRANT.
- IDLE:
  - If Req != 0 at a rising edge, pick the first set bit scanning Last+1, Last+2, ... mod 4.
  - At that edge: Gnt=onehot(winner), Sel=winner, Busy=1, counter=0, state goes to GRANT.
  - Latency: Req seen at edge k gives Gnt visible after edge k (1 cycle).
- GRANT, evaluated each edge on the owner o = Sel:
  - Release if Done[o]=1, or Req[o]=0, or counter==MAX_HOLD-1.
  - On release: Gnt=0, Busy=0, Last=o, state goes to IDLE.
  - Otherwise counter increments.
  - A grant therefore lasts at most MAX_HOLD cycles.
- Mandatory one-cycle idle bubble between consecutive grants. Re-arbitration happens in IDLE the next edge.
- Done or Req changes from non-owners are ignored in GRANT. Done in IDLE is ignored.
- Simultaneous Done[o] and timeout: a single release, no double update of Last.
- Owner re-requesting right after release is serviced only after the other pending requesters (Last=o).
- Sel holds its last value in IDLE; Dout is forced to 0 whenever Busy=0.
- Gnt is always one-hot or zero. Assertion: $onehot0(Gnt); Busy == |Gnt.
- Reset mid-grant: outputs return to reset values immediately (asynchronous), and Last returns to 3.

Optional Feature:
- Macro: ARB_PREEMPT_EN.
- Defined: requester 0 is urgent. If Req[0]=1 while in GRANT with owner != 0, the grant is released at the next edge as if Done were pulsed (Last=owner). The next IDLE cycle grants requester 0 regardless of round-robin order. Owner 0 is never preempted.
- Undefined: pure round-robin, no preemption. Req[0] waits like any other requester.

Test Plan:
- Reset then Req=0001, Din0=8'hA5 -> after 1 edge Gnt=0001, Sel=0, Busy=1, Dout=A5. Done[0] pulse -> next edge Gnt=0000, Dout=00.
- Req=1111 held, each owner pulses Done 3 cycles after grant -> grant order 0,1,2,3,0, with exactly one idle cycle between grants.
- Req=0100 held, no Done, MAX_HOLD=15 -> Gnt=0100 for exactly 15 cycles, 1 idle, then re-granted to 2 (sole requester).
- Owner 1 granted, Done=0100 pulse (non-owner), Req[3] toggling -> Gnt stays 0010, counter unaffected.
- Reset asserted mid-grant at cycle 5 of owner 2 -> Gnt, Busy, Sel, Dout go to 0 immediately. After release with Req=1111 -> first grant to 0.
- With ARB_PREEMPT_EN: owner 2 granted, Req[0] rises -> next edge Gnt=0000, following edge Gnt=0001. Without the macro, requester 0 waits until owner 2 releases, then requester 3 is granted first if requesting.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 data mux with a request/grant/done handshake.
// Optional macro ARB_PREEMPT_EN makes requester 0 urgent (preempts any other owner).
module mux_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [3:0]    Req,
  input  logic [3:0]    Done,
  input  logic [DW-1:0] Din0,
  input  logic [DW-1:0] Din1,
  input  logic [DW-1:0] Din2,
  input  logic [DW-1:0] Din3,
  output logic [3:0]    Gnt,
  output logic [1:0]    Sel,
  output logic [DW-1:0] Dout,
  output logic          Busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q;
  logic [3:0]        gnt_q;
  logic [1:0]        sel_q;
  logic              busy_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [1:0]        last_q;

  logic [1:0]        win_d;
  logic              rel_d;
  logic              urgent_d;

  // Scan Last+1, Last+2, ... so the previous owner is visited last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win_d = last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && Req[idx]) begin
        win_d = idx;
        found = 1'b1;
      end
    end
`ifdef ARB_PREEMPT_EN
    if (Req[0]) win_d = 2'd0;
`endif
  end

`ifdef ARB_PREEMPT_EN
  assign urgent_d = Req[0] && (sel_q != 2'd0);
`else
  assign urgent_d = 1'b0;
`endif

  // Only the owner's Done/Req matter; timeout and Done together are one release.
  assign rel_d = Done[sel_q] || !Req[sel_q] ||
                 (cnt_q == HOLD_W'(MAX_HOLD - 1)) || urgent_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      case (state_q)
        IDLE: begin
          if (|Req) begin
            state_q <= GRANT;
            gnt_q   <= 4'(1) << win_d;
            sel_q   <= win_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (rel_d) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            last_q  <= sel_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-level 2:1 select tree, gated so an idle bus reads as zero.
  logic [DW-1:0] m01, m23, mux;
  assign m01  = sel_q[0] ? Din1 : Din0;
  assign m23  = sel_q[0] ? Din3 : Din2;
  assign mux  = sel_q[1] ? m23 : m01;
  assign Dout = busy_q ? mux : '0;

  assign Gnt  = gnt_q;
  assign Sel  = sel_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized self-checking bench for mux_rr_arbiter against a cycle-level ownership model.
module tb_mux_rr_arbiter;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 15;
  localparam int HOLD_W   = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [3:0]    Req, Done;
  logic [DW-1:0] Din0, Din1, Din2, Din3;
  logic [3:0]    Gnt;
  logic [1:0]    Sel;
  logic [DW-1:0] Dout;
  logic          Busy;

  int nvec = 0;
  int nerr = 0;

  // Model state: owner index (-1 when idle), last owner, visible grant length.
  int m_owner, m_last, m_sel, m_len;

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Done(Done),
    .Din0(Din0), .Din1(Din1), .Din2(Din2), .Din3(Din3),
    .Gnt(Gnt), .Sel(Sel), .Dout(Dout), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] din_of(input int i);
    case (i)
      0: return Din0;
      1: return Din1;
      2: return Din2;
      default: return Din3;
    endcase
  endfunction

  function automatic logic [DW+6:0] exp_vec();
    logic [3:0] g;
    logic b;
    b = (m_owner >= 0);
    g = b ? 4'(1 << m_owner) : 4'b0000;
    return {g, 2'(m_sel), b, b ? din_of(m_sel) : {DW{1'b0}}};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_sel = 0; m_len = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] d);
    int  win;
    bit  pre;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        win = -1;
`ifdef ARB_PREEMPT_EN
        if (r[0]) win = 0;
`endif
        for (int k = 1; k <= 4 && win < 0; k++)
          if (r[(m_last + k) % 4]) win = (m_last + k) % 4;
        m_owner = win; m_sel = win; m_len = 1;
      end
    end else begin
      pre = 1'b0;
`ifdef ARB_PREEMPT_EN
      pre = r[0] && (m_owner != 0);
`endif
      if (d[m_owner] || !r[m_owner] || m_len == MAX_HOLD || pre) begin
        m_last = m_owner; m_owner = -1;
      end else m_len++;
    end
  endtask

  // Called at a negedge: drive inputs, take one edge, return at the next negedge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] d);
    Req = r; Done = d;
    Din0 = DW'($urandom); Din1 = DW'($urandom); Din2 = DW'($urandom); Din3 = DW'($urandom);
    @(posedge Clock);
    model_edge(r, d);
    @(negedge Clock);
    Done = 4'b0000;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; Req = 4'b0000; Done = 4'b0000;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({Gnt, Sel, Busy, Dout} !== {4'b0000, 2'd0, 1'b0, {DW{1'b0}}}) begin
      nerr++;
      $display("FAIL reset_state: got gnt=%b sel=%0d busy=%b dout=%h, want all zero", Gnt, Sel, Busy, Dout);
    end
  endtask

  task automatic test_basic();
    do_reset();
    Req = 4'b0001; Din0 = 8'hA5; Din1 = 8'h11; Din2 = 8'h22; Din3 = 8'h33;
    @(posedge Clock); model_edge(4'b0001, 4'b0000); @(negedge Clock);
    nvec++;
    if ({Gnt, Sel, Busy, Dout} !== {4'b0001, 2'd0, 1'b1, 8'hA5}) begin
      nerr++;
      $display("FAIL basic_grant: got gnt=%b sel=%0d busy=%b dout=%h, want 0001/0/1/a5", Gnt, Sel, Busy, Dout);
    end
    cyc(4'b0001, 4'b0001);
    nvec++;
    if ({Gnt, Busy, Dout} !== {4'b0000, 1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL basic_release: got gnt=%b busy=%b dout=%h, want 0000/0/00", Gnt, Busy, Dout);
    end
  endtask

  task automatic test_rr_order();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int age = 0, idle = 0;
    logic [3:0] d;
    bit was_busy = 1'b0;
    do_reset();
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      d = (Busy && age == 3) ? Gnt : 4'b0000;
      cyc(4'b1111, d);
      nvec++;
      if ({Gnt, Sel, Busy, Dout} !== exp_vec()) begin
        nerr++;
        $display("FAIL rr_model c=%0d: got %h want %h", c, {Gnt, Sel, Busy, Dout}, exp_vec());
      end
      if (Busy && !was_busy) begin
        order.push_back(int'(Sel));
        if (order.size() > 1) begin
          nvec++;
          if (idle !== 1) begin
            nerr++;
            $display("FAIL rr_gap: got %0d idle cycles, want 1", idle);
          end
        end
        age = 0; idle = 0;
      end
      if (Busy) age++; else idle++;
      was_busy = Busy;
    end
    nvec++;
    if (order.size() != 5) begin
      nerr++;
      $display("FAIL rr_count: got %0d grants, want 5", order.size());
    end else
      for (int i = 0; i < 5; i++) begin
        nvec++;
        if (order[i] !== exp_order[i]) begin
          nerr++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
        end
      end
  endtask

  task automatic test_timeout();
    int held = 0;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      cyc(4'b0100, 4'b0000);
      if (Gnt == 4'b0100 && c < 16) held++;
      nvec++;
      if ({Gnt, Sel, Busy, Dout} !== exp_vec()) begin
        nerr++;
        $display("FAIL timeout_model c=%0d: got %h want %h", c, {Gnt, Sel, Busy, Dout}, exp_vec());
      end
      if (c == 15) begin
        nvec++;
        if (Gnt !== 4'b0000) begin
          nerr++;
          $display("FAIL timeout_bubble: got gnt=%b want 0000", Gnt);
        end
      end
    end
    nvec++;
    if (held !== MAX_HOLD || Gnt !== 4'b0100) begin
      nerr++;
      $display("FAIL timeout_len: got held=%0d gnt=%b, want %0d and 0100", held, Gnt, MAX_HOLD);
    end
  endtask

  task automatic test_nonowner();
    int held = 0;
    do_reset();
    cyc(4'b0010, 4'b0000);
    held = 1;
    for (int c = 0; c < 6; c++) begin
      cyc({c[0], 3'b010}, 4'b0100);
      nvec++;
      if (Gnt !== 4'b0010) begin
        nerr++;
        $display("FAIL nonowner_hold c=%0d: got gnt=%b want 0010", c, Gnt);
      end
      held++;
    end
    for (int c = 0; c < 20 && Busy; c++) begin
      cyc(4'b0010, 4'b0000);
      if (Busy) held++;
    end
    nvec++;
    if (held !== MAX_HOLD) begin
      nerr++;
      $display("FAIL nonowner_cnt: got grant length %0d want %0d", held, MAX_HOLD);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 5; c++) cyc(4'b0100, 4'b0000);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    nvec++;
    if ({Gnt, Sel, Busy, Dout} !== {4'b0000, 2'd0, 1'b0, {DW{1'b0}}}) begin
      nerr++;
      $display("FAIL reset_mid: got gnt=%b sel=%0d busy=%b dout=%h, want all zero", Gnt, Sel, Busy, Dout);
    end
    @(negedge Clock);
    Reset = 1'b0;
    cyc(4'b1111, 4'b0000);
    nvec++;
    if (Gnt !== 4'b0001) begin
      nerr++;
      $display("FAIL reset_regrant: got gnt=%b want 0001", Gnt);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    cyc(4'b0100, 4'b0000);
    cyc(4'b1101, 4'b0000);
`ifdef ARB_PREEMPT_EN
    nvec++;
    if (Gnt !== 4'b0000) begin
      nerr++;
      $display("FAIL preempt_release: got gnt=%b want 0000", Gnt);
    end
    cyc(4'b1101, 4'b0000);
    nvec++;
    if (Gnt !== 4'b0001) begin
      nerr++;
      $display("FAIL preempt_grant0: got gnt=%b want 0001", Gnt);
    end
`else
    nvec++;
    if (Gnt !== 4'b0100) begin
      nerr++;
      $display("FAIL nopreempt_hold: got gnt=%b want 0100", Gnt);
    end
    cyc(4'b1101, 4'b0100);
    cyc(4'b1101, 4'b0000);
    nvec++;
    if (Gnt !== 4'b1000) begin
      nerr++;
      $display("FAIL nopreempt_next: got gnt=%b want 1000", Gnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] r, d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = 4'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cyc(r, d);
      nvec++;
      if ({Gnt, Sel, Busy, Dout} !== exp_vec() || !$onehot0(Gnt) || Busy !== (|Gnt)) begin
        nerr++;
        $display("FAIL random c=%0d req=%b done=%b: got %h want %h", c, r, d, {Gnt, Sel, Busy, Dout}, exp_vec());
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Req = 4'b0000; Done = 4'b0000;
    Din0 = '0; Din1 = '0; Din2 = '0; Din3 = '0;
    model_reset();
    test_reset();
    test_basic();
    test_rr_order();
    test_timeout();
    test_nonowner();
    test_reset_mid();
    test_preempt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
